// File: rtl/multicycle_fsm_if.sv
// Control bus between the multicycle FSM and its datapath / instruction register.
// Latency: n/a (wires only).
// Backpressure: mem_ready from the memory side stalls FETCH, MEMRD and MEMWR.
//
// Optional feature macro: MULTICYCLE_FSM_PERFCNT_EN adds the CNT_W parameter and
// the retired-instruction count signal.
//
// master : datapath side (drives Op, Funct, mem_ready; receives controls)
// slave  : FSM side      (receives Op, Funct, mem_ready; drives controls)
interface multicycle_fsm_if
`ifdef MULTICYCLE_FSM_PERFCNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic       ALUOp;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       instr_done;
  logic       illegal;
`ifdef MULTICYCLE_FSM_PERFCNT_EN
  logic [CNT_W-1:0] retired;
`endif

  modport master (
    output Op, Funct, mem_ready,
    input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUOp,
    input  ALUSrcB, ResultSrc, instr_done, illegal
`ifdef MULTICYCLE_FSM_PERFCNT_EN
    , input retired
`endif
  );

  modport slave (
    input  Op, Funct, mem_ready,
    output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUOp,
    output ALUSrcB, ResultSrc, instr_done, illegal
`ifdef MULTICYCLE_FSM_PERFCNT_EN
    , output retired
`endif
  );
endinterface

// File: rtl/multicycle_fsm.sv
// Main decoder FSM of a multicycle processor (Moore control outputs per state).
// Latency: data-processing 4, load 5, store 4, branch 3 cycles with mem_ready=1.
// Backpressure: mem_ready=0 holds FETCH, MEMRD or MEMWR one extra cycle each.
//
// Ports: clk (rising edge), rst (async, active low), bus (multicycle_fsm_if.slave:
// Op/Funct/mem_ready in, datapath enables and mux selects out), state_o (debug).
// Optional feature macro: MULTICYCLE_FSM_PERFCNT_EN adds a wrapping retired
// instruction counter of width CNT_W on bus.retired.
module multicycle_fsm
`ifdef MULTICYCLE_FSM_PERFCNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_fsm_if.slave        bus,
  output logic [3:0]             state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;

  // Raw enables before the reset gate.
  logic       irw_raw, npc_raw, regw_raw, memw_raw, done_raw, ill_raw;
  logic       branch_d, adrsrc_d, alusrca_d, aluop_d;
  logic [1:0] alusrcb_d, resultsrc_d;

  // Only the immediate and load/store bits of Funct steer this FSM.
  logic       unused_funct;
  assign unused_funct = ^bus.Funct[4:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    irw_raw     = 1'b0;
    npc_raw     = 1'b0;
    regw_raw    = 1'b0;
    memw_raw    = 1'b0;
    done_raw    = 1'b0;
    ill_raw     = 1'b0;
    branch_d    = 1'b0;
    adrsrc_d    = 1'b0;
    alusrca_d   = 1'b0;
    aluop_d     = 1'b0;
    alusrcb_d   = 2'b00;
    resultsrc_d = 2'b00;
    case (state_q)
      S_FETCH: begin
        alusrca_d   = 1'b1;
        alusrcb_d   = 2'b10;
        resultsrc_d = 2'b10;
        irw_raw     = bus.mem_ready;
        npc_raw     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrca_d   = 1'b1;
        alusrcb_d   = 2'b10;
        resultsrc_d = 2'b10;
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: begin
            state_d = S_FETCH;
            ill_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrcb_d = 2'b01;
        state_d   = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adrsrc_d = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc_d = 2'b01;
        regw_raw    = 1'b1;
        done_raw    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        // MemW stays up across wait cycles; the store retires on the ready cycle.
        adrsrc_d = 1'b1;
        memw_raw = 1'b1;
        done_raw = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        aluop_d = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        aluop_d   = 1'b1;
        alusrcb_d = 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        regw_raw = 1'b1;
        done_raw = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrcb_d   = 2'b01;
        resultsrc_d = 2'b10;
        branch_d    = 1'b1;
        done_raw    = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Side-effecting enables are forced low while reset is held, including the
  // mem_ready-driven ones in FETCH, so an aborted instruction never retires.
  assign bus.IRWrite    = irw_raw  & rst;
  assign bus.NextPC     = npc_raw  & rst;
  assign bus.RegW       = regw_raw & rst;
  assign bus.MemW       = memw_raw & rst;
  assign bus.instr_done = done_raw & rst;
  assign bus.illegal    = ill_raw  & rst;
  assign bus.Branch     = branch_d;
  assign bus.AdrSrc     = adrsrc_d;
  assign bus.ALUSrcA    = alusrca_d;
  assign bus.ALUOp      = aluop_d;
  assign bus.ALUSrcB    = alusrcb_d;
  assign bus.ResultSrc  = resultsrc_d;
  assign state_o        = state_q;

`ifdef MULTICYCLE_FSM_PERFCNT_EN
  logic [CNT_W-1:0] retired_q;

  // Natural binary wrap from all-ones to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                retired_q <= '0;
    else if (bus.instr_done) retired_q <= retired_q + CNT_W'(1);
  end

  assign bus.retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_fsm.sv
module tb_multicycle_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] state_o;

`ifdef MULTICYCLE_FSM_PERFCNT_EN
  localparam int CW = 4;
  multicycle_fsm_if #(.CNT_W(CW)) bus();
  multicycle_fsm #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus), .state_o(state_o));
  int exp_ret = 0;
`else
  multicycle_fsm_if bus();
  multicycle_fsm dut (.clk(clk), .rst(rst), .bus(bus), .state_o(state_o));
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw, npc, regw, memw, branch, adrsrc, alusrca, aluop;
    logic [1:0] alusrcb, resultsrc;
    logic       done, ill;
  } ctl_t;

  int total = 0;
  int bad   = 0;

  int   q_st[$];
  bit   q_rdy[$];
  ctl_t obs[$];
  int   obs_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Control vector each state must present, straight from the state table.
  function automatic ctl_t spec_ctl(input int s, input bit rdy, input logic [1:0] op);
    ctl_t c = '0;
    case (s)
      0: begin c.alusrca = 1; c.alusrcb = 2; c.resultsrc = 2; c.irw = rdy; c.npc = rdy; end
      1: begin c.alusrca = 1; c.alusrcb = 2; c.resultsrc = 2; c.ill = (op == 2'b11); end
      2: begin c.alusrcb = 1; end
      3: begin c.adrsrc = 1; end
      4: begin c.resultsrc = 1; c.regw = 1; c.done = 1; end
      5: begin c.adrsrc = 1; c.memw = 1; c.done = rdy; end
      6: begin c.aluop = 1; end
      7: begin c.aluop = 1; c.alusrcb = 1; end
      8: begin c.regw = 1; c.done = 1; end
      9: begin c.alusrcb = 1; c.resultsrc = 2; c.branch = 1; c.done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c.irw = bus.IRWrite;   c.npc = bus.NextPC;   c.regw = bus.RegW;     c.memw = bus.MemW;
    c.branch = bus.Branch; c.adrsrc = bus.AdrSrc; c.alusrca = bus.ALUSrcA; c.aluop = bus.ALUOp;
    c.alusrcb = bus.ALUSrcB; c.resultsrc = bus.ResultSrc;
    c.done = bus.instr_done; c.ill = bus.illegal;
    return c;
  endfunction

  function automatic int mask_of(input int f);
    int m = 0;
    foreach (obs[i]) begin
      bit b;
      case (f)
        0: b = obs[i].regw;
        1: b = obs[i].memw;
        2: b = obs[i].done;
        3: b = obs[i].ill;
        default: b = obs[i].branch;
      endcase
      if (b) m |= (1 << i);
    end
    return m;
  endfunction

  // Model: expected state per cycle of one instruction, and the mem_ready to drive.
  task automatic push(input int s, input bit r);
    q_st.push_back(s);
    q_rdy.push_back(r);
  endtask

  task automatic build(input logic [1:0] op, input logic [5:0] fn, input int fw, input int mw);
    repeat (fw) push(0, 0);
    push(0, 1);
    push(1, 1);
    case (op)
      2'b00: begin push(fn[5] ? 7 : 6, 1); push(8, 1); end
      2'b01: begin
        push(2, 1);
        if (fn[0]) begin repeat (mw) push(3, 0); push(3, 1); push(4, 1); end
        else       begin repeat (mw) push(5, 0); push(5, 1); end
      end
      2'b10: push(9, 1);
      default: ;
    endcase
  endtask

  // Called on a falling edge; returns on a falling edge. max_steps truncates the run.
  task automatic run(input logic [1:0] op, input logic [5:0] fn, input int fw, input int mw,
                     input int max_steps);
    int   s;
    bit   r;
    int   n = 0;
    ctl_t e;
    q_st.delete(); q_rdy.delete(); obs.delete(); obs_code = 0;
    build(op, fn, fw, mw);
    while (q_st.size() > 0 && n < max_steps) begin
      s = q_st.pop_front();
      r = q_rdy.pop_front();
      bus.Op = op; bus.Funct = fn; bus.mem_ready = r;
      #2;
      e = spec_ctl(s, r, op);
      check("state", 32'(state_o), 32'(s));
      check("ctl", 32'(dut_ctl()), 32'(e));
`ifdef MULTICYCLE_FSM_PERFCNT_EN
      check("retired", 32'(bus.retired), 32'(exp_ret));
      if (e.done) exp_ret = (exp_ret + 1) % (1 << CW);
`endif
      obs.push_back(dut_ctl());
      obs_code = obs_code * 16 + int'(state_o);
      n++;
      @(negedge clk);
    end
    q_st.delete(); q_rdy.delete();
  endtask

  initial begin
    bus.Op = 2'b00; bus.Funct = 6'd0; bus.mem_ready = 1'b1;
    @(negedge clk);
    #2;
    // In reset with mem_ready=1: FETCH, side-effecting enables all low.
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ctl", 32'(dut_ctl()), 32'(spec_ctl(0, 0, 2'b00)));
`ifdef MULTICYCLE_FSM_PERFCNT_EN
    check("rst_retired", 32'(bus.retired), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    run(2'b00, 6'b000100, 0, 0, 99);            // ADD register
    check("add_trace", 32'(obs_code), 32'h0168);
    check("add_regw",  32'(mask_of(0)), 32'b1000);
    check("add_done",  32'(mask_of(2)), 32'b1000);

    run(2'b01, 6'b000001, 0, 2, 99);            // LDR, 2 wait cycles
    check("ldr_trace", 32'(obs_code), 32'h0123334);
    check("ldr_regw",  32'(mask_of(0)), 32'h40);
    check("ldr_rsrc",  32'(obs[6].resultsrc), 32'd1);

    run(2'b01, 6'b000000, 0, 1, 99);            // STR, 1 wait cycle
    check("str_memw",  32'(mask_of(1)), 32'h18);
    check("str_done",  32'(mask_of(2)), 32'h10);
    check("str_regw",  32'(mask_of(0)), 32'd0);

    run(2'b11, 6'b000000, 0, 0, 99);            // illegal
    check("ill_trace", 32'(obs_code), 32'h01);
    check("ill_pulse", 32'(mask_of(3)), 32'b10);
    check("ill_done",  32'(mask_of(2)), 32'd0);

    run(2'b10, 6'b000000, 0, 0, 99);            // branch
    check("b_trace",  32'(obs_code), 32'h019);
    check("b_branch", 32'(mask_of(4)), 32'b100);

    run(2'b00, 6'b100000, 2, 0, 99);            // EXECI after 2 fetch waits
    check("addi_trace", 32'(obs_code), 32'h000178);
    run(2'b01, 6'b100001, 1, 0, 99);            // LDR immediate, fetch wait
    check("ldr2_trace", 32'(obs_code), 32'h001234);
    run(2'b01, 6'b100000, 0, 0, 99);            // STR, no waits
    check("str2_trace", 32'(obs_code), 32'h0125);

    // Async reset in the middle of EXECI.
    run(2'b00, 6'b100000, 0, 0, 2);
    #2;
    check("execi_state", 32'(state_o), 32'd7);
    #1 rst = 1'b0;
    #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_regw",  32'(bus.RegW), 32'd0);
    check("arst_done",  32'(bus.instr_done), 32'd0);
    check("arst_irw",   32'(bus.IRWrite), 32'd0);
`ifdef MULTICYCLE_FSM_PERFCNT_EN
    check("arst_retired", 32'(bus.retired), 32'd0);
    exp_ret = 0;
`endif
    @(negedge clk);
    #2;
    check("arst_hold", 32'(state_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(2'b00, 6'b000100, 0, 0, 99);            // restart from FETCH
    check("post_rst_trace", 32'(obs_code), 32'h0168);

`ifdef MULTICYCLE_FSM_PERFCNT_EN
    // Drive the narrow counter through all-ones and back to zero.
    for (int i = 0; i < 16; i++) run(2'b10, 6'b000000, 0, 0, 99);
    #2;
    check("wrap_retired", 32'(bus.retired), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 Parameter: CNT_W, 32, width of the retired-instruction counter (only present with MULTICYCLE_FSM_PERFCNT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 Op  input  2  instruction class from the instruction register: 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-005 Funct  input  6  instruction funct field; Funct[5] is the immediate bit, Funct[0] is the load/store bit.
REQ-006 mem_ready  input  1  memory handshake; 1 means the current access completes this cycle.
REQ-007 IRWrite, NextPC, RegW, MemW, Branch  output  1 each  datapath enables; RegW, MemW and Branch are later qualified by the conditional logic.
REQ-008 AdrSrc, ALUSrcA, ALUOp  output  1 each  address mux select, ALU A mux select, and ALU-decode enable.
REQ-009 ALUSrcB, ResultSrc  output  2 each  ALU B mux select and result mux select.
REQ-010 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-011 illegal  output  1  one-cycle pulse when Op=11 is decoded.
REQ-012 state_o  output  4  current state encoding, for debug.
REQ-013 retired  output  CNT_W  retired-instruction count (only with MULTICYCLE_FSM_PERFCNT_EN).

Function
REQ-014 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-015 Outputs SHALL be decoded from the state only (Moore); mem_ready qualifies only IRWrite, NextPC and instr_done. Any output not listed for a state SHALL be 0.
REQ-016 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, and IRWrite=NextPC=mem_ready; FETCH->DECODE when mem_ready=1, otherwise FETCH holds.
REQ-017 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Transitions: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECR; Op=00 with Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->FETCH with illegal=1 for that cycle.
REQ-018 MEMADR: ALUSrcA=0, ALUSrcB=01; goes to MEMRD if Funct[0]=1, otherwise MEMWR.
REQ-019 MEMRD: AdrSrc=1, ResultSrc=00; goes to MEMWB when mem_ready=1, otherwise holds.
REQ-020 MEMWB: ResultSrc=01, RegW=1, instr_done=1; goes to FETCH.
REQ-021 MEMWR: AdrSrc=1, ResultSrc=00, MemW=1 for every cycle spent in the state; goes to FETCH with instr_done=1 when mem_ready=1, otherwise holds.
REQ-022 EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1; goes to ALUWB. EXECI: the same outputs but ALUSrcB=01; goes to ALUWB.
REQ-023 ALUWB: ResultSrc=00, RegW=1, instr_done=1; goes to FETCH.
REQ-024 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, instr_done=1; goes to FETCH.
REQ-025 Latency with mem_ready held at 1: data-processing 4 cycles, load 5, store 4, branch 3. Each wait cycle (mem_ready=0) adds one cycle to FETCH, MEMRD or MEMWR.

Reset
REQ-026 While rst=0, state SHALL be FETCH, and IRWrite, NextPC, RegW, MemW, instr_done and illegal SHALL be forced to 0.
REQ-027 Reset asserted mid-instruction SHALL abort the instruction without a retire pulse. The first active edge after rst rises SHALL evaluate FETCH.

Configuration
REQ-028 With MULTICYCLE_FSM_PERFCNT_EN defined: retired resets to 0, increments by 1 on each instr_done, and wraps from all-ones to 0.
REQ-029 Without MULTICYCLE_FSM_PERFCNT_EN: the retired port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 ADD register (Op=00, Funct=000100), mem_ready=1 -> states 0,1,6,8; RegW=1 in cycle 4 only; instr_done pulse in cycle 4.
REQ-031 LDR (Op=01, Funct[0]=1), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; RegW with ResultSrc=01 only in state 4.
REQ-032 STR (Op=01, Funct[0]=0), mem_ready=0 for 1 cycle in MEMWR -> MemW=1 for 2 cycles; instr_done only on the ready cycle; RegW never 1.
REQ-033 Op=11 -> illegal pulse in DECODE, return to FETCH, no instr_done; B (Op=10) -> Branch=1 in cycle 3.
REQ-034 rst driven low asynchronously during EXECI -> state_o=0 immediately and RegW=0; with PERFCNT, retired loaded with all-ones wraps to 0 on the next retire.
